// File: rtl/rv_wb_arbiter_if.sv
// rv_wb_arbiter_if: bundle of the two master-side Wishbone ports and the single
// slave-side port handled by rv_wb_arbiter.
// Signal names are given from the arbiter's point of view (i_ = into arbiter).
//   m0/m1 : adr, dat, we, sel, stb, cyc in; dat, ack, err out
//   slave : adr, dat, we, sel, stb, cyc out; ack, dat in
// Modports: slave  - used by the arbiter itself
//           master - used by whatever drives the masters / models the slave
interface rv_wb_arbiter_if;
    logic [31:0] i_m0_adr, i_m1_adr;
    logic [31:0] i_m0_dat, i_m1_dat;
    logic        i_m0_we,  i_m1_we;
    logic [3:0]  i_m0_sel, i_m1_sel;
    logic        i_m0_stb, i_m1_stb;
    logic        i_m0_cyc, i_m1_cyc;
    logic [31:0] o_m0_dat, o_m1_dat;
    logic        o_m0_ack, o_m1_ack;
    logic        o_m0_err, o_m1_err;
    logic [31:0] o_s_adr;
    logic [31:0] o_s_dat;
    logic        o_s_we;
    logic [3:0]  o_s_sel;
    logic        o_s_stb;
    logic        o_s_cyc;
    logic        i_s_ack;
    logic [31:0] i_s_dat;

    modport slave (
        input  i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat, i_m0_we, i_m1_we,
               i_m0_sel, i_m1_sel, i_m0_stb, i_m1_stb, i_m0_cyc, i_m1_cyc,
               i_s_ack, i_s_dat,
        output o_m0_dat, o_m1_dat, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err,
               o_s_adr, o_s_dat, o_s_we, o_s_sel, o_s_stb, o_s_cyc
    );

    modport master (
        output i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat, i_m0_we, i_m1_we,
               i_m0_sel, i_m1_sel, i_m0_stb, i_m1_stb, i_m0_cyc, i_m1_cyc,
               i_s_ack, i_s_dat,
        input  o_m0_dat, o_m1_dat, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err,
               o_s_adr, o_s_dat, o_s_we, o_s_sel, o_s_stb, o_s_cyc
    );
endinterface

// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: two-master to one-slave Wishbone classic arbiter.
// Round-robin grant held for the whole bus cycle (until the granted master
// drops cyc). One cycle of arbitration latency; a freed grant always passes
// through one idle slave cycle before the next grant.
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - asynchronous active-high reset
//   bus     - rv_wb_arbiter_if.slave: both master ports and the slave port
// Parameter TIMEOUT_CYCLES: stalled-strobe limit for the watchdog.
// Optional macro RV_WB_ARB_TIMEOUT_EN builds the watchdog; without it the
// err outputs are tied low and a hung slave keeps the grant forever.
module rv_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           i_clk,
    input  logic           i_reset,
    rv_wb_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]  r_state, w_next;
    logic        r_last;
    logic        w_req0, w_req1, w_gnt, w_sel1, w_tmo;
    logic [31:0] w_m_adr, w_m_dat;
    logic [3:0]  w_m_sel;
    logic        w_m_we, w_m_stb, w_m_cyc;

    assign w_req0 = bus.i_m0_cyc & bus.i_m0_stb;
    assign w_req1 = bus.i_m1_cyc & bus.i_m1_stb;
    assign w_gnt  = (r_state == S_GNT0) | (r_state == S_GNT1);
    assign w_sel1 = (r_state == S_GNT1);

    // Granted master's request, selected by state
    assign w_m_adr = w_sel1 ? bus.i_m1_adr : bus.i_m0_adr;
    assign w_m_dat = w_sel1 ? bus.i_m1_dat : bus.i_m0_dat;
    assign w_m_we  = w_sel1 ? bus.i_m1_we  : bus.i_m0_we;
    assign w_m_sel = w_sel1 ? bus.i_m1_sel : bus.i_m0_sel;
    assign w_m_stb = w_sel1 ? bus.i_m1_stb : bus.i_m0_stb;
    assign w_m_cyc = w_sel1 ? bus.i_m1_cyc : bus.i_m0_cyc;

`ifdef RV_WB_ARB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    // Counts cycles the granted strobe waits for ack; any ack restarts it.
    // Outside a grant it sits at zero, which covers the clear-on-entry case.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_tmo_cnt <= '0;
        else if (!w_gnt || bus.i_s_ack || w_tmo)
            r_tmo_cnt <= '0;
        else if (w_m_stb)
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end

    // An ack on the terminal cycle wins over the timeout
    assign w_tmo = w_gnt & (r_tmo_cnt == TMO_LIMIT) & ~bus.i_s_ack;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO_LIMIT;
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req0 && w_req1)
                    w_next = r_last ? S_GNT0 : S_GNT1;
                else if (w_req0)
                    w_next = S_GNT0;
                else if (w_req1)
                    w_next = S_GNT1;
            end
            S_GNT0:  if (!bus.i_m0_cyc || w_tmo) w_next = S_IDLE;
            S_GNT1:  if (!bus.i_m1_cyc || w_tmo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_GNT0) r_last <= 1'b0;
            if (r_state == S_IDLE && w_next == S_GNT1) r_last <= 1'b1;
        end
    end

    // Slave side: zero while idle; cyc/stb suppressed on the timeout cycle
    assign bus.o_s_adr = w_gnt ? w_m_adr : '0;
    assign bus.o_s_dat = w_gnt ? w_m_dat : '0;
    assign bus.o_s_we  = w_gnt & w_m_we;
    assign bus.o_s_sel = w_gnt ? w_m_sel : '0;
    assign bus.o_s_stb = w_gnt & w_m_stb & ~w_tmo;
    assign bus.o_s_cyc = w_gnt & w_m_cyc & ~w_tmo;

    // Master side: read data broadcast, ack/err only to the owner
    assign bus.o_m0_dat = bus.i_s_dat;
    assign bus.o_m1_dat = bus.i_s_dat;
    assign bus.o_m0_ack = (r_state == S_GNT0) & bus.i_s_ack;
    assign bus.o_m1_ack = (r_state == S_GNT1) & bus.i_s_ack;
    assign bus.o_m0_err = (r_state == S_GNT0) & w_tmo;
    assign bus.o_m1_err = (r_state == S_GNT1) & w_tmo;
endmodule

// File: tb/tb_rv_wb_arbiter.sv
module tb_rv_wb_arbiter;
`ifdef RV_WB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 8;
    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic        stb;
        logic        cyc;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  ack;
        logic [1:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_wb_arbiter_if bus();
    rv_wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic        s_ack;
    logic [31:0] s_dat;

    assign bus.i_m0_adr = m_adr[0];  assign bus.i_m1_adr = m_adr[1];
    assign bus.i_m0_dat = m_dat[0];  assign bus.i_m1_dat = m_dat[1];
    assign bus.i_m0_we  = m_we[0];   assign bus.i_m1_we  = m_we[1];
    assign bus.i_m0_sel = m_sel[0];  assign bus.i_m1_sel = m_sel[1];
    assign bus.i_m0_stb = m_stb[0];  assign bus.i_m1_stb = m_stb[1];
    assign bus.i_m0_cyc = m_cyc[0];  assign bus.i_m1_cyc = m_cyc[1];
    assign bus.i_s_ack  = s_ack;
    assign bus.i_s_dat  = s_dat;

    int checks = 0;
    int errors = 0;
    int n_err  = 0;
    int cycno  = 0;
    exp_t expq[$];
    logic [31:0] obs_grants[$];

    // Reference model: who owns the bus, who was served last, how long the
    // current strobe has been waiting.
    int   owner = -1;
    int   last  = 1;
    int   stall = 0;
    exp_t last_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic set_m(input int n, input logic c, input logic s, input logic [31:0] a,
                         input logic w, input logic [3:0] se, input logic [31:0] d);
        m_cyc[n] = c; m_stb[n] = s; m_adr[n] = a; m_we[n] = w; m_sel[n] = se; m_dat[n] = d;
    endtask

    // Predict this cycle's outputs from the current inputs, queue them,
    // advance the model across the coming edge, then wait for it.
    task automatic step();
        exp_t e;
        logic hit, r0, r1;
        int   n;
        e = '0; hit = 1'b0;
        e.rd0 = s_dat; e.rd1 = s_dat;
        if (!rst && owner >= 0) begin
            n = owner;
            hit = TMO_EN && (stall == TMO) && !s_ack;
            e.adr = m_adr[n]; e.dat = m_dat[n]; e.we = m_we[n]; e.sel = m_sel[n];
            e.stb = m_stb[n] & !hit;
            e.cyc = m_cyc[n] & !hit;
            e.ack[n] = s_ack;
            e.err[n] = hit;
        end
        expq.push_back(e);
        last_exp = e;
        if (rst) begin
            owner = -1; last = 1; stall = 0;
        end else if (owner < 0) begin
            r0 = m_cyc[0] & m_stb[0];
            r1 = m_cyc[1] & m_stb[1];
            if (r0 && r1) owner = 1 - last;
            else if (r0)  owner = 0;
            else if (r1)  owner = 1;
            if (owner >= 0) begin last = owner; stall = 0; end
        end else if (hit || !m_cyc[owner]) begin
            owner = -1;
        end else if (s_ack) begin
            stall = 0;
        end else if (m_stb[owner]) begin
            stall++;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    // Monitor: compares the DUT against the oldest queued prediction
    logic prev_scyc = 1'b0;
    always @(negedge clk) begin
        exp_t a, e;
        cycno++;
        if (bus.o_m0_err | bus.o_m1_err) n_err++;
        if (bus.o_s_cyc && !prev_scyc) obs_grants.push_back(bus.o_s_adr);
        prev_scyc = bus.o_s_cyc;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a.adr = bus.o_s_adr; a.dat = bus.o_s_dat; a.we = bus.o_s_we; a.sel = bus.o_s_sel;
            a.stb = bus.o_s_stb; a.cyc = bus.o_s_cyc;
            a.rd0 = bus.o_m0_dat; a.rd1 = bus.o_m1_dat;
            a.ack = {bus.o_m1_ack, bus.o_m0_ack};
            a.err = {bus.o_m1_err, bus.o_m0_err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard cycle %0d act=%h exp=%h", cycno, a, e);
            end
        end
    end

    int beats [2];
    int hang;

    initial begin
        for (int n = 0; n < 2; n++) set_m(n, 0, 0, 0, 0, 0, 0);
        s_ack = 1'b0; s_dat = 32'h0;
        @(posedge clk); #1;
        do_reset();

        // 1: single m0 read, ack two cycles after grant
        set_m(0, 1, 1, 32'h8000_0010, 0, 4'hF, 0);
        step(); step(); step();
        s_ack = 1'b1; s_dat = 32'hDEAD_BEEF; step();
        s_ack = 1'b0; set_m(0, 0, 0, 0, 0, 0, 0); step(); step();

        // 2: simultaneous requests three times -> m0, m1, m0
        do_reset();
        obs_grants.delete();
        set_m(0, 1, 1, A0, 0, 4'hF, 0);
        set_m(1, 1, 1, A1, 1, 4'h3, 32'h1111_2222);
        for (int r = 0; r < 3; r++) begin
            int g;
            step();
            s_ack = 1'b1; step();
            s_ack = 1'b0; g = owner;
            m_cyc[g] = 1'b0; m_stb[g] = 1'b0; step();
            m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
        end
        set_m(0, 0, 0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0, 0, 0);
        step(); step();
        chk("t2_ngrants", obs_grants.size(), 3);
        if (obs_grants.size() == 3) begin
            chk("t2_grant0", obs_grants[0], A0);
            chk("t2_grant1", obs_grants[1], A1);
            chk("t2_grant2", obs_grants[2], A0);
        end

        // 3: m0 4-beat write, m1 requests at beat 1 and waits
        do_reset();
        obs_grants.delete();
        set_m(0, 1, 1, A0, 1, 4'b0011, 32'hA000_0000);
        step();
        for (int k = 0; k < 4; k++) begin
            s_ack = 1'b1; m_dat[0] = 32'hA000_0000 + k;
            if (k == 1) set_m(1, 1, 1, A1, 0, 4'hF, 0);
            step();
        end
        s_ack = 1'b0; set_m(0, 0, 0, 0, 0, 0, 0); step();
        step(); step();
        s_ack = 1'b1; step();
        s_ack = 1'b0; set_m(1, 0, 0, 0, 0, 0, 0); step(); step();
        chk("t3_ngrants", obs_grants.size(), 2);
        if (obs_grants.size() == 2) begin
            chk("t3_grant0", obs_grants[0], A0);
            chk("t3_grant1", obs_grants[1], A1);
        end

        // 4: asynchronous reset mid-cycle while m1 holds the bus
        set_m(1, 1, 1, A1, 1, 4'hF, 32'h5555_AAAA);
        step(); step();
        s_ack = 1'b1; #1;
        rst = 1'b1; owner = -1; last = 1; stall = 0; #1;
        chk("t4_scyc", bus.o_s_cyc, 0);
        chk("t4_sstb", bus.o_s_stb, 0);
        chk("t4_ack",  {bus.o_m1_ack, bus.o_m0_ack}, 0);
        chk("t4_err",  {bus.o_m1_err, bus.o_m0_err}, 0);
        step();
        rst = 1'b0; s_ack = 1'b0;
        obs_grants.delete();
        set_m(0, 1, 1, A0, 0, 4'hF, 0);
        step(); step();
        chk("t4_tie_m0", (obs_grants.size() > 0) ? obs_grants[0] : 32'hFFFF_FFFF, A0);
        set_m(0, 0, 0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0, 0, 0); step(); step();

        // 5: slave never acks
        do_reset();
        n_err = 0;
        set_m(0, 1, 1, A0, 0, 4'hF, 0);
        for (int k = 0; k < 13; k++) step();
        set_m(0, 0, 0, 0, 0, 0, 0); step(); step();
        chk("t5_err_pulses", n_err, TMO_EN ? 1 : 0);

        // 6: ack on the terminal cycle wins over the timeout
        do_reset();
        n_err = 0;
        set_m(0, 1, 1, A0, 0, 4'hF, 0);
        step();
        for (int k = 0; k < TMO; k++) step();
        s_ack = 1'b1; s_dat = 32'hC0FF_EE00; step();
        s_ack = 1'b0; set_m(0, 0, 0, 0, 0, 0, 0); step(); step();
        chk("t6_err_pulses", n_err, 0);

        // Random traffic, with occasional hung-slave windows
        do_reset();
        beats[0] = 0; beats[1] = 0; hang = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!m_cyc[n]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_m(n, 1, 1, $urandom, 1'($urandom), 4'($urandom), $urandom);
                        beats[n] = $urandom_range(1, 4);
                    end
                end else begin
                    if (last_exp.ack[n]) begin
                        beats[n]--;
                        m_dat[n] = $urandom;
                    end
                    if (beats[n] <= 0 || last_exp.err[n]) begin
                        m_cyc[n] = 1'b0; m_stb[n] = 1'b0;
                    end else begin
                        m_stb[n] = ($urandom_range(0, 3) != 0);
                    end
                end
            end
            if (hang > 0) hang--;
            else if ($urandom_range(0, 60) == 0) hang = $urandom_range(5, 14);
            s_ack = (hang == 0) && ($urandom_range(0, 2) == 0);
            s_dat = $urandom;
            step();
        end
        set_m(0, 0, 0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0, 0, 0);
        s_ack = 1'b0; step(); step();
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
